// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execution unit: ALUOp, MIPS Funct codes,
// internal ALU control codes, FSM states and the decoded-operation payload.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [3:0] CTL_AND   = 4'b0000;
    localparam logic [3:0] CTL_OR    = 4'b0001;
    localparam logic [3:0] CTL_XOR   = 4'b0010;
    localparam logic [3:0] CTL_NOR   = 4'b0011;
    localparam logic [3:0] CTL_SLT   = 4'b0100;
    localparam logic [3:0] CTL_SLL   = 4'b0101;
    localparam logic [3:0] CTL_SRL   = 4'b0110;
    localparam logic [3:0] CTL_ADD   = 4'b0111;
    localparam logic [3:0] CTL_SUB   = 4'b1000;
    localparam logic [3:0] CTL_SRA   = 4'b1001;
    localparam logic [3:0] CTL_MFHI  = 4'b1010;
    localparam logic [3:0] CTL_MFLO  = 4'b1011;
    localparam logic [3:0] CTL_MULT  = 4'b1100;
    localparam logic [3:0] CTL_MULTU = 4'b1101;
    localparam logic [3:0] CTL_DIV   = 4'b1110;
    localparam logic [3:0] CTL_DIVU  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIN  = 2'b11
    } state_t;

    typedef struct packed {
        logic [3:0] ctl;
        logic       ill;
    } dec_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between an issuing stage and the ALU execution unit.
interface alu_exec_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
);
    logic             valid_in;
    logic [1:0]       ALUOp;
    logic [5:0]       Funct;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [SHW-1:0]   shamt;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output valid_in, ALUOp, Funct, A, B, shamt,
        input  ready, done, result, zero, illegal, hi, lo
    );

    modport slave (
        input  valid_in, ALUOp, Funct, A, B, shamt,
        output ready, done, result, zero, illegal, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide
// on unsigned magnitudes, one bit per cycle, with the shared iteration counter.
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_step,
    input  logic               i_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_last,
    output logic [2*WIDTH-1:0] o_prod,
    output logic [WIDTH-1:0]   o_quot,
    output logic [WIDTH-1:0]   o_rem
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_hi;   // product upper half / partial remainder
    logic [WIDTH-1:0] r_lo;   // multiplier / dividend-quotient shift register
    logic [WIDTH-1:0] r_b;    // multiplicand / divisor
    logic             r_div;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    always_comb begin
        w_sum   = r_hi + (r_lo[0] ? {1'b0, r_b} : '0);
        w_trial = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
        w_diff  = w_trial - {1'b0, r_b};
        w_ge    = (w_trial >= {1'b0, r_b});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
        end else if (i_start) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= i_a;
            r_b   <= i_b;
            r_div <= i_div;
        end else if (i_step) begin
            if (!o_last) r_cnt <= r_cnt + CW'(1);
            if (r_div) begin
                r_hi <= w_ge ? w_diff : w_trial;
                r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end else begin
                r_hi <= {1'b0, w_sum[WIDTH:1]};
                r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    assign o_last = (r_cnt == CW'(WIDTH - 1));
    assign o_prod = {r_hi[WIDTH-1:0], r_lo};
    assign o_quot = r_lo;
    assign o_rem  = r_hi[WIDTH-1:0];

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: decode, single-cycle ALU, multi-cycle MUL/DIV sequencing
// and the architectural HI/LO registers.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    alu_exec_unit_if.slave    bus
);
    state_t           r_state;
    logic             r_ready, r_done, r_illegal, r_zero;
    logic [WIDTH-1:0] r_result, r_hi, r_lo, r_a;
    logic             r_is_div, r_neg_p, r_neg_q, r_neg_r, r_divz;

    dec_t             w_dec;
    logic             w_accept, w_multi, w_is_div, w_signed, w_a_neg, w_b_neg;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu, w_a_mag, w_b_mag, w_quo, w_rem, w_fin_hi, w_fin_lo;
    logic [2*WIDTH-1:0] w_prod, w_mdu_prod;
    logic [WIDTH-1:0] w_mdu_quot, w_mdu_rem;
    logic             w_last;

    // Decode ALUOp/Funct into a control code; anything unknown is illegal.
    always_comb begin
        w_dec.ctl = CTL_ADD;
        w_dec.ill = 1'b0;
        case (bus.ALUOp)
            ALUOP_ADD:   w_dec.ctl = CTL_ADD;
            ALUOP_SUB:   w_dec.ctl = CTL_SUB;
            ALUOP_RTYPE: begin
                case (bus.Funct)
                    FN_ADD, FN_JR: w_dec.ctl = CTL_ADD;
                    FN_SUB:        w_dec.ctl = CTL_SUB;
                    FN_AND:        w_dec.ctl = CTL_AND;
                    FN_OR:         w_dec.ctl = CTL_OR;
                    FN_XOR:        w_dec.ctl = CTL_XOR;
                    FN_NOR:        w_dec.ctl = CTL_NOR;
                    FN_SLT:        w_dec.ctl = CTL_SLT;
                    FN_SLL:        w_dec.ctl = CTL_SLL;
                    FN_SRL:        w_dec.ctl = CTL_SRL;
                    FN_SRA:        w_dec.ctl = CTL_SRA;
                    FN_MFHI:       w_dec.ctl = CTL_MFHI;
                    FN_MFLO:       w_dec.ctl = CTL_MFLO;
                    FN_MULT:       w_dec.ctl = CTL_MULT;
                    FN_MULTU:      w_dec.ctl = CTL_MULTU;
                    FN_DIV:        w_dec.ctl = CTL_DIV;
                    FN_DIVU:       w_dec.ctl = CTL_DIVU;
                    default:       w_dec.ill = 1'b1;
                endcase
            end
            default: w_dec.ill = 1'b1;
        endcase
    end

    assign w_shamt  = bus.shamt;
    assign w_accept = bus.valid_in && r_ready;
    assign w_multi  = !w_dec.ill && (w_dec.ctl[3:2] == 2'b11);
    assign w_is_div = w_dec.ctl[1];
    assign w_signed = !w_dec.ctl[0];
    assign w_a_neg  = w_signed && bus.A[WIDTH-1];
    assign w_b_neg  = w_signed && bus.B[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.A : bus.A;
    assign w_b_mag  = w_b_neg ? -bus.B : bus.B;

    // Single-cycle ALU.
    always_comb begin
        w_alu = '0;
        case (w_dec.ctl)
            CTL_ADD:  w_alu = bus.A + bus.B;
            CTL_SUB:  w_alu = bus.A - bus.B;
            CTL_AND:  w_alu = bus.A & bus.B;
            CTL_OR:   w_alu = bus.A | bus.B;
            CTL_XOR:  w_alu = bus.A ^ bus.B;
            CTL_NOR:  w_alu = ~(bus.A | bus.B);
            CTL_SLT:  w_alu = WIDTH'($signed(bus.A) < $signed(bus.B));
            CTL_SLL:  w_alu = bus.B << w_shamt;
            CTL_SRL:  w_alu = bus.B >> w_shamt;
            CTL_SRA:  w_alu = $signed(bus.B) >>> w_shamt;
            CTL_MFHI: w_alu = r_hi;
            CTL_MFLO: w_alu = r_lo;
            default:  w_alu = '0;
        endcase
    end

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk     (clk),
        .rst     (rst),
        .i_start ((r_state == S_IDLE) && w_accept && w_multi),
        .i_step  ((r_state == S_MUL) || (r_state == S_DIV)),
        .i_div   (w_is_div),
        .i_a     (w_a_mag),
        .i_b     (w_b_mag),
        .o_last  (w_last),
        .o_prod  (w_mdu_prod),
        .o_quot  (w_mdu_quot),
        .o_rem   (w_mdu_rem)
    );

    // Sign fix-up of the unsigned MDU result; divide by zero is forced explicitly.
    always_comb begin
        w_prod   = r_neg_p ? -w_mdu_prod : w_mdu_prod;
        w_quo    = r_divz ? '1  : (r_neg_q ? -w_mdu_quot : w_mdu_quot);
        w_rem    = r_divz ? r_a : (r_neg_r ? -w_mdu_rem  : w_mdu_rem);
        w_fin_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        w_fin_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_hi      <= '0;
            r_lo      <= '0;
            r_a       <= '0;
            r_is_div  <= 1'b0;
            r_neg_p   <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_divz    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_dec.ill) begin
                            r_done    <= 1'b1;
                            r_illegal <= 1'b1;
                            r_result  <= '0;
                            r_zero    <= 1'b1;
                        end else if (w_multi) begin
                            r_state  <= w_is_div ? S_DIV : S_MUL;
                            r_ready  <= 1'b0;
                            r_a      <= bus.A;
                            r_is_div <= w_is_div;
                            r_neg_p  <= w_a_neg ^ w_b_neg;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_divz   <= w_is_div && (bus.B == '0);
                        end else begin
                            r_done   <= 1'b1;
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (w_last) r_state <= S_FIN;
                end
                S_FIN: begin
                    r_hi     <= w_fin_hi;
                    r_lo     <= w_fin_lo;
                    r_result <= w_fin_lo;
                    r_zero   <= (w_fin_lo == '0);
                    r_done   <= 1'b1;
                    r_ready  <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready   = r_ready;
    assign bus.done    = r_done;
    assign bus.illegal = r_illegal;
    assign bus.result  = r_result;
    assign bus.zero    = r_zero;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit at WIDTH=32 and WIDTH=8.
module tb_alu_exec_unit;

    localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_SRA = 6'b000011;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010;
    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV = 6'b011010, F_DIVU = 6'b011011;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(32)) if32 ();
    alu_exec_unit_if #(.WIDTH(8))  if8 ();

    alu_exec_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));
    alu_exec_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));

    task automatic issue32(input logic [1:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        if32.valid_in = 1'b1; if32.ALUOp = op; if32.Funct = fn;
        if32.A = a; if32.B = b; if32.shamt = sh;
        @(posedge clk); #1;
        if32.valid_in = 1'b0;
    endtask

    task automatic wait_done32(output int lat, output int rdy_low);
        lat = 0; rdy_low = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!if32.ready) rdy_low++;
        end while (!if32.done && lat < 100);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        if32.valid_in = 1'b0; if32.ALUOp = 2'b00; if32.Funct = 6'd0;
        if32.A = '0; if32.B = '0; if32.shamt = '0;
        if8.valid_in = 1'b0; if8.ALUOp = 2'b00; if8.Funct = 6'd0;
        if8.A = '0; if8.B = '0; if8.shamt = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        checks++; if (if32.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", if32.ready); end
        checks++; if (if32.done !== 1'b0 || if32.illegal !== 1'b0) begin errors++; $display("FAIL reset_done_illegal: got %b%b expected 00", if32.done, if32.illegal); end
        checks++; if (if32.result !== 32'h0 || if32.zero !== 1'b1) begin errors++; $display("FAIL reset_result_zero: got %h/%b expected 0/1", if32.result, if32.zero); end
        checks++; if (if32.hi !== 32'h0 || if32.lo !== 32'h0) begin errors++; $display("FAIL reset_hilo: got %h/%h expected 0/0", if32.hi, if32.lo); end
    endtask

    task automatic test_single_cycle;
        issue32(2'b10, F_ADD, 32'd5, 32'hFFFF_FFFB, 5'd0);
        checks++; if (if32.done !== 1'b1 || if32.result !== 32'h0 || if32.zero !== 1'b1) begin errors++; $display("FAIL add_wrap: got done=%b res=%h zero=%b expected 1/00000000/1", if32.done, if32.result, if32.zero); end
        @(posedge clk); #1;
        checks++; if (if32.done !== 1'b0 || if32.result !== 32'h0) begin errors++; $display("FAIL done_pulse_hold: got done=%b res=%h expected 0/00000000", if32.done, if32.result); end
        issue32(2'b01, 6'd0, 32'd3, 32'd5, 5'd0);
        checks++; if (if32.result !== 32'hFFFF_FFFE || if32.zero !== 1'b0) begin errors++; $display("FAIL aluop_sub: got %h/%b expected FFFFFFFE/0", if32.result, if32.zero); end
        issue32(2'b10, F_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
        checks++; if (if32.result !== 32'h1) begin errors++; $display("FAIL slt_signed: got %h expected 00000001", if32.result); end
        issue32(2'b10, F_NOR, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0);
        checks++; if (if32.result !== 32'h0F0F_F0F0) begin errors++; $display("FAIL nor: got %h expected 0F0FF0F0", if32.result); end
    endtask

    task automatic test_back_to_back;
        if32.valid_in = 1'b1; if32.ALUOp = 2'b00; if32.A = 32'd10; if32.B = 32'd20;
        @(posedge clk); #1;
        checks++; if (if32.result !== 32'd30 || if32.ready !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h ready=%b expected 0000001E ready=1", if32.result, if32.ready); end
        if32.ALUOp = 2'b01; if32.A = 32'd100; if32.B = 32'd1;
        @(posedge clk); #1;
        if32.valid_in = 1'b0;
        checks++; if (if32.result !== 32'd99 || if32.done !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h done=%b expected 00000063 done=1", if32.result, if32.done); end
    endtask

    task automatic test_mult;
        int lat, rlow;
        issue32(2'b10, F_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0);
        checks++; if (if32.ready !== 1'b0) begin errors++; $display("FAIL mult_busy: got ready=%b expected 0", if32.ready); end
        wait_done32(lat, rlow);
        checks++; if (lat != 33 || rlow != 32) begin errors++; $display("FAIL mult_latency: got lat=%0d ready_low=%0d expected 33/32", lat, rlow); end
        checks++; if (if32.hi !== 32'hFFFF_FFFF || if32.lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_hilo: got %h_%h expected FFFFFFFF_FFFFFFEB", if32.hi, if32.lo); end
        checks++; if (if32.result !== 32'hFFFF_FFEB || if32.ready !== 1'b1) begin errors++; $display("FAIL mult_result: got %h ready=%b expected FFFFFFEB ready=1", if32.result, if32.ready); end
        issue32(2'b10, F_MFHI, 32'd0, 32'd0, 5'd0);
        checks++; if (if32.result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mfhi_after_mult: got %h expected FFFFFFFF", if32.result); end
        issue32(2'b10, F_MFLO, 32'd0, 32'd0, 5'd0);
        checks++; if (if32.result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mflo_after_mult: got %h expected FFFFFFEB", if32.result); end
    endtask

    task automatic test_div;
        int lat, rlow;
        issue32(2'b10, F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);
        wait_done32(lat, rlow);
        checks++; if (lat != 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", lat); end
        checks++; if (if32.lo !== 32'hFFFF_FFFD || if32.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_signed: got hi=%h lo=%h expected FFFFFFFF/FFFFFFFD", if32.hi, if32.lo); end
        issue32(2'b10, F_DIVU, 32'd7, 32'd0, 5'd0);
        wait_done32(lat, rlow);
        checks++; if (lat != 33 || if32.illegal !== 1'b0) begin errors++; $display("FAIL divz_timing: got lat=%0d illegal=%b expected 33/0", lat, if32.illegal); end
        checks++; if (if32.lo !== 32'hFFFF_FFFF || if32.hi !== 32'd7) begin errors++; $display("FAIL divz_hilo: got hi=%h lo=%h expected 00000007/FFFFFFFF", if32.hi, if32.lo); end
    endtask

    task automatic test_abort;
        int dones;
        dones = 0;
        issue32(2'b10, F_MULTU, 32'd3, 32'd5, 5'd0);
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) begin
                if32.valid_in = 1'b1; if32.ALUOp = 2'b00; if32.A = 32'd1; if32.B = 32'd1;
            end else begin
                if32.valid_in = 1'b0;
            end
            @(posedge clk); #1;
            if (if32.done) dones++;
        end
        if32.valid_in = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (dones != 0) begin errors++; $display("FAIL abort_busy_ignored: got %0d done pulses expected 0", dones); end
        checks++; if (if32.ready !== 1'b1 || if32.hi !== 32'h0 || if32.lo !== 32'h0) begin errors++; $display("FAIL abort_state: got ready=%b hi=%h lo=%h expected 1/0/0", if32.ready, if32.hi, if32.lo); end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (if32.done) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", dones); end
        issue32(2'b00, 6'd0, 32'd1, 32'd2, 5'd0);
        checks++; if (if32.result !== 32'd3 || if32.done !== 1'b1) begin errors++; $display("FAIL abort_recover: got %h done=%b expected 00000003/1", if32.result, if32.done); end
    endtask

    task automatic test_shift_illegal;
        issue32(2'b10, F_SRA, 32'h1234_5678, 32'h8000_0000, 5'd31);
        checks++; if (if32.result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra31: got %h expected FFFFFFFF", if32.result); end
        issue32(2'b10, F_SRL, 32'hFFFF_FFFF, 32'h8000_0000, 5'd31);
        checks++; if (if32.result !== 32'h1) begin errors++; $display("FAIL srl31: got %h expected 00000001", if32.result); end
        issue32(2'b10, F_SLL, 32'hFFFF_FFFF, 32'h0000_0003, 5'd4);
        checks++; if (if32.result !== 32'h30) begin errors++; $display("FAIL sll4: got %h expected 00000030", if32.result); end
        issue32(2'b11, F_ADD, 32'd9, 32'd9, 5'd0);
        checks++; if (if32.done !== 1'b1 || if32.illegal !== 1'b1 || if32.result !== 32'h0 || if32.zero !== 1'b1) begin errors++; $display("FAIL illegal_aluop: got done=%b ill=%b res=%h zero=%b expected 1/1/0/1", if32.done, if32.illegal, if32.result, if32.zero); end
        @(posedge clk); #1;
        checks++; if (if32.illegal !== 1'b0 || if32.done !== 1'b0) begin errors++; $display("FAIL illegal_pulse: got ill=%b done=%b expected 0/0", if32.illegal, if32.done); end
        issue32(2'b10, 6'b111111, 32'd9, 32'd9, 5'd0);
        checks++; if (if32.illegal !== 1'b1 || if32.done !== 1'b1) begin errors++; $display("FAIL illegal_funct: got ill=%b done=%b expected 1/1", if32.illegal, if32.done); end
    endtask

    task automatic test_width8;
        int lat;
        if8.valid_in = 1'b1; if8.ALUOp = 2'b10; if8.Funct = F_MULTU;
        if8.A = 8'hFF; if8.B = 8'hFF; if8.shamt = '0;
        @(posedge clk); #1;
        if8.valid_in = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!if8.done && lat < 50);
        checks++; if (lat != 9) begin errors++; $display("FAIL w8_latency: got %0d expected 9", lat); end
        checks++; if ({if8.hi, if8.lo} !== 16'hFE01) begin errors++; $display("FAIL w8_multu: got %h expected FE01", {if8.hi, if8.lo}); end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_back_to_back();
        test_mult();
        test_div();
        test_abort();
        test_shift_illegal();
        test_width8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 valid_in  input  1  operation request; accepted on a clock edge where valid_in=1 and ready=1.
REQ-006 ALUOp  input  2  00=add, 01=subtract, 10=R-type (decode Funct), 11=illegal.
REQ-007 Funct  input  6  MIPS R-type function field.
REQ-008 A, B  input  WIDTH  operands; rs=A, rt=B.
REQ-009 shamt  input  SHW  shift amount for sll/srl/sra.
REQ-010 ready  output  1  unit idle, can accept a request.
REQ-011 done  output  1  one-cycle pulse; result valid in the same cycle.
REQ-012 result  output  WIDTH  registered result; held until the next done.
REQ-013 zero  output  1  result==0, registered together with result.
REQ-014 illegal  output  1  one-cycle pulse with done for an undecodable ALUOp/Funct.
REQ-015 hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-016 Single-cycle ops: add, sub, and, or, xor, nor, slt (signed), sll, srl, sra, jr (add), mfhi (010000), mflo (010010); done and result 1 cycle after accept; ready stays 1.
REQ-017 Multi-cycle ops: mult 011000, multu 011001, div 011010, divu 011011; ready=0 from the cycle after accept until done.
REQ-018 States: IDLE, MUL, DIV, FIN. IDLE->MUL/DIV on an accepted multi-cycle op; MUL/DIV->FIN when the iteration counter reaches WIDTH-1; FIN->IDLE unconditionally; done pulses in FIN.
REQ-019 Multiply: shift-add on operand magnitudes, one bit per cycle, sign applied in FIN for mult; {hi,lo}=full 2*WIDTH product.
REQ-020 Divide: restoring, one quotient bit per cycle; lo=quotient, hi=remainder; signed div truncates toward zero, remainder takes the dividend's sign.
REQ-021 Divide by zero: still takes the full latency; lo=all ones, hi=A; illegal not asserted.
REQ-022 Multi-cycle latency: done exactly WIDTH+1 cycles after the accept edge; result=lo in that cycle.
REQ-023 hi/lo update only in FIN; single-cycle ops never modify them; mfhi issued back-to-back after FIN returns the new value.
REQ-024 valid_in while ready=0 is ignored, with no queuing.
REQ-025 Illegal ALUOp or unknown Funct: done and illegal pulse 1 cycle later; result=0, zero=1.
REQ-026 add/sub wrap modulo 2^WIDTH; no overflow trap.
REQ-027 Shifts use shamt only; B is the shifted operand.

Reset
REQ-028 When rst=1 at an edge: state=IDLE, counter=0, ready=1, done=0, illegal=0, result=0, zero=1, hi=0, lo=0.
REQ-029 Reset during MUL/DIV aborts the operation: no done, hi/lo cleared, request not replayed.
REQ-030 rst overrides a simultaneous valid_in; that request is dropped.

Structure
REQ-031 Shared package alu_pkg holds the ALUOp encodings, Funct codes, 4-bit ALUControl codes (and=0000 … add=0111, sub=1000, mul=1100) and the state enumeration.
REQ-032 One sub-module, mdu_iter, holds the multiply/divide iteration datapath and counter; the top-level module holds the decoding, single-cycle ALU, FSM and HI/LO.

Verification (WIDTH=32)
REQ-033 Sequence:
 - Reset.
 - Add: ALUOp=10, Funct=100000, A=5, B=0xFFFFFFFB.
 - Required response: done after 1 cycle, result=0, zero=1.
REQ-034 Sequence:
 - Multiply: mult, A=-3, B=7.
 - Required response: ready=0 for 32 cycles, done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
 - Then mfhi returns 0xFFFFFFFF.
REQ-035 Sequence:
 - Divide: div, A=-7, B=2.
 - Required response: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
 - Then divu A=7, B=0: lo=0xFFFFFFFF, hi=7, illegal=0.
REQ-036 Sequence:
 - Start multu.
 - Pulse valid_in with add during the busy period.
 - Assert rst at cycle 10.
 - Required response: add ignored, no done, hi=lo=0, ready=1 next cycle.
REQ-037 Sequence:
 - Shifts: sra A=x, B=0x80000000, shamt=31.
 - Required response: result=0xFFFFFFFF.
 - Then ALUOp=11: illegal and done pulse, result=0.
REQ-038 Sequence:
 - Parameter sweep: WIDTH=8, multu 255×255.
 - Required response: {hi,lo}=0xFE01, done 9 cycles after accept.
